// File: rtl/sweep_response_capture_pkg.sv
// Shared definitions for the sweep response capture path:
// default widths and the capture FSM state encoding.
package sweep_response_capture_pkg;

    localparam int FREQ_W_DEF = 32;
    localparam int ADC_W_DEF  = 12;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2
    } cap_state_t;

endpackage

// File: rtl/sweep_response_capture_minmax_tracker.sv
// Running min/max tracker over a stream of unsigned samples.
// Ports: clk, rstn, clear (restart tracking), sample_valid, sample in;
// min_val/max_val out, already folding in the current valid sample.
module minmax_tracker #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic         sample_valid,
    input  logic [W-1:0] sample,
    output logic [W-1:0] min_val,
    output logic [W-1:0] max_val
);

    logic [W-1:0] min_q;
    logic [W-1:0] max_q;

    // Outputs include the sample presented this cycle so the owner can
    // take a final result on the same edge that the last sample arrives.
    always_comb begin
        min_val = min_q;
        max_val = max_q;
        if (sample_valid && (sample < min_q)) min_val = sample;
        if (sample_valid && (sample > max_q)) max_val = sample;
    end

    // clear dominates so a result taken this cycle still sees old state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            min_q <= '1;
            max_q <= '0;
        end else if (clear) begin
            min_q <= '1;
            max_q <= '0;
        end else if (sample_valid) begin
            min_q <= min_val;
            max_q <= max_val;
        end
    end

endmodule

// File: rtl/sweep_response_capture.sv
// Detects frequency steps/wraps on the DDS ramp, waits a settle time,
// then measures peak-to-peak ADC amplitude and emits (freq, amp).
// Ports: cfg_write/cfg_settle/cfg_window config, enable, freq_word,
// adc_valid/adc_data in; res_valid/res_ready/res_freq/res_amp stream;
// sweep_wrap pulse, busy, drop_cnt status.
module sweep_response_capture
    import sweep_response_capture_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int ADC_W  = ADC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_write,
    input  logic [CNT_W-1:0]  cfg_settle,
    input  logic [CNT_W-1:0]  cfg_window,
    input  logic              enable,
    input  logic [FREQ_W-1:0] freq_word,
    input  logic              adc_valid,
    input  logic [ADC_W-1:0]  adc_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [FREQ_W-1:0] res_freq,
    output logic [ADC_W-1:0]  res_amp,
    output logic              sweep_wrap,
    output logic              busy,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    cap_state_t        state;
    logic [FREQ_W-1:0] freq_prev;
    logic [FREQ_W-1:0] cur_freq;
    logic [CNT_W-1:0]  buf_settle;
    logic [CNT_W-1:0]  buf_window;
    logic [CNT_W-1:0]  act_settle;
    logic [CNT_W-1:0]  act_window;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  nsamp;
    logic [ADC_W-1:0]  trk_min;
    logic [ADC_W-1:0]  trk_max;

    logic step_evt;
    logic measuring;
    logic sample_en;
    logic complete;
    logic abort;
    logic slot_free;
    logic load;
    logic drop;
    logic trk_clear;

    assign step_evt  = enable & (freq_word != freq_prev);
    assign measuring = (state == MEASURE);
    assign sample_en = measuring & adc_valid & enable;
    assign complete  = sample_en & (nsamp == act_window - ONE);
    // completion wins over a coincident step, so that is not an abort
    assign abort     = step_evt & (state != IDLE) & ~complete;
    assign slot_free = ~res_valid | res_ready;
    assign load      = complete & slot_free;
    assign drop      = abort | (complete & ~slot_free);
    assign trk_clear = step_evt | ~measuring;
    assign busy      = (state != IDLE);

    minmax_tracker #(
        .W(ADC_W)
    ) u_tracker (
        .clk          (clk),
        .rstn         (rstn),
        .clear        (trk_clear),
        .sample_valid (sample_en),
        .sample       (adc_data),
        .min_val      (trk_min),
        .max_val      (trk_max)
    );

    // Edge detection and wrap pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            freq_prev  <= '0;
            sweep_wrap <= 1'b0;
        end else begin
            freq_prev  <= freq_word;
            sweep_wrap <= enable & (freq_word < freq_prev);
        end
    end

    // Config buffers; a zero window is stored as one sample
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_settle <= '0;
            buf_window <= ONE;
        end else if (cfg_write) begin
            buf_settle <= cfg_settle;
            buf_window <= (cfg_window == '0) ? ONE : cfg_window;
        end
    end

    // Capture FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cur_freq   <= '0;
            act_settle <= '0;
            act_window <= ONE;
            cnt        <= '0;
            nsamp      <= '0;
        end else if (!enable) begin
            state <= IDLE;
        end else if (step_evt) begin
            cur_freq   <= freq_word;
            act_settle <= buf_settle;
            act_window <= buf_window;
            cnt        <= '0;
            nsamp      <= '0;
            state      <= (buf_settle == '0) ? MEASURE : SETTLE;
        end else begin
            case (state)
                SETTLE: begin
                    if (cnt == act_settle - ONE) begin
                        state <= MEASURE;
                        nsamp <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                MEASURE: begin
                    if (sample_en) begin
                        nsamp <= nsamp + ONE;
                        if (complete) state <= IDLE;
                    end
                end
                IDLE:    ;
                default: state <= IDLE;
            endcase
        end
    end

    // Single-entry result slot
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_valid <= 1'b0;
            res_freq  <= '0;
            res_amp   <= '0;
        end else if (load) begin
            res_valid <= 1'b1;
            res_freq  <= cur_freq;
            res_amp   <= trk_max - trk_min;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Saturating loss counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + ONE;
        end
    end

endmodule

// File: doc/sweep_response_capture.md
Name: sweep_response_capture

Overview:
- Consumer end of the DDS ramp path. Watches the 32-bit frequency word produced by the sweep ramp generator and detects every step and every wrap.
- For each step it waits a programmable settle time, then measures peak-to-peak ADC amplitude over a programmable number of samples.
- Emits one (frequency, amplitude) result per step on a valid/ready stream to the readout logic.
- Sits between the DDS/ADC front end and the result FIFO/UART packer.

Parameters:
- FREQ_W, 32, width of frequency word.
- ADC_W, 12, ADC sample width, unsigned offset binary.
- CNT_W, 16, width of settle/window/drop counters.

Ports:
- clk  in  1  system clock; all inputs synchronous to it, including freq_word.
- rstn  in  1  reset, asynchronous, active-low.
- cfg_write  in  1  one-cycle strobe; latches cfg_settle and cfg_window.
- cfg_settle  in  CNT_W  settle time in clk cycles after a step.
- cfg_window  in  CNT_W  ADC samples per measurement; 0 treated as 1.
- enable  in  1  capture enable.
- freq_word  in  FREQ_W  current ramp output.
- adc_valid  in  1  adc_data qualifier.
- adc_data  in  ADC_W  ADC sample.
- res_valid  out  1  result slot full.
- res_ready  in  1  downstream accept.
- res_freq  out  FREQ_W  frequency word of the measured step.
- res_amp  out  ADC_W  max minus min over the window.
- sweep_wrap  out  1  one-cycle pulse when the sweep restarts.
- busy  out  1  FSM not in IDLE.
- drop_cnt  out  CNT_W  saturating count of lost results/aborted steps.

Behaviour:
- Reset: every output is 0; FSM is IDLE; config registers reset to settle=0, window=1; freq_prev=0.
- freq_prev <= freq_word every cycle.
- step_evt = enable & (freq_word != freq_prev).
- sweep_wrap registered: asserted the cycle after enable & (freq_word < freq_prev).
- cfg_write updates the config buffers only. Active settle/window copies load on every step_evt. A config change therefore never disturbs an in-flight measurement.
- FSM states: IDLE, SETTLE, MEASURE.
  - IDLE: on step_evt in cycle T, latch cur_freq=freq_word and active config, cnt=0. Go to SETTLE, or go to MEASURE if settle==0.
  - SETTLE: cnt increments each cycle. When cnt==settle-1, go to MEASURE with min=all-ones, max=0, nsamp=0. SETTLE occupies cycles T+1..T+S.
  - MEASURE: on each adc_valid, update min/max (the sample itself counts) and increment nsamp. On the sample where nsamp reaches window, complete the measurement and go to IDLE.
  - step_evt in SETTLE or MEASURE: abort, drop_cnt++, relatch cur_freq/config and restart as from IDLE in the same cycle.
- Latency: with adc_valid constant high, res_valid rises in cycle T+S+W+1.
- Result slot (single entry, independent of FSM):
  - On completion, load res_freq=cur_freq and res_amp=max-min if the slot is empty or res_ready is high that cycle. Otherwise drop the result and increment drop_cnt.
  - res_valid stays high until res_valid & res_ready. Data is stable while valid is high.
- enable low: FSM goes to IDLE next cycle; in-flight measurement discarded without counting as a drop. Result slot unaffected.
- drop_cnt saturates at all-ones; cleared only by reset.
- Simultaneous completion and step_evt: completion wins (result loaded), and the new step starts in the same cycle.
- Asynchronous reset mid-operation: everything returns to reset values immediately; no partial result emitted.

Decomposition:
- Shared dds package holds FREQ_W/ADC_W defaults and the FSM state enum (IDLE=0, SETTLE=1, MEASURE=2).
- One natural sub-module: minmax_tracker (clear, sample_valid, sample in; min/max out) for reuse by the future amplitude-detector blocks.

Test Plan:
- Reset, then settle=4, window=8, adc_valid=1.
  - Stimulus: freq_word 0→100 at cycle T; adc ramps 10..17.
  - Required: res_valid at T+13, res_freq=100, res_amp=7.
- settle=0, window=0 (treated as 1).
  - Stimulus: step to 0x200; adc=0x5A5.
  - Required: res_valid at T+2, res_amp=0.
- Abort.
  - Stimulus: step to 100, then step to 200 during MEASURE.
  - Required: drop_cnt=1; a single result with res_freq=200.
- Backpressure.
  - Stimulus: res_ready=0 across two completed steps.
  - Required: first result held stable; second dropped; drop_cnt=1; after res_ready=1, res_valid falls next cycle.
- Wrap.
  - Stimulus: freq_word 0xFFFF_0000 → 0x1000.
  - Required: sweep_wrap single pulse the following cycle, and a new measurement starts.
- Mid-operation disable and reset.
  - Stimulus: enable low during SETTLE.
  - Required: busy=0 next cycle, no result, drop_cnt unchanged.
  - Stimulus: rstn low during MEASURE.
  - Required: all outputs 0 immediately.
